// File: rtl/sdram_initiator_if.sv
// Client command/response channel plus the CPU-clock SDRAM port handshake.
// master = the initiator's view, slave = the client/controller side.
interface sdram_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;

  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_in;
  logic        sdram_req;
  logic        sdram_write;
  logic        sdram_ready;
  logic        sdram_done;
  logic [31:0] sdram_data_out;

  logic        busy;
  logic [7:0]  err_count;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           sdram_ready, sdram_done, sdram_data_out,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           sdram_addr, sdram_data_in, sdram_req, sdram_write, busy, err_count
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           sdram_ready, sdram_done, sdram_data_out,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
           sdram_addr, sdram_data_in, sdram_req, sdram_write, busy, err_count
  );
endinterface

// File: rtl/sdram_initiator.sv
// Single-outstanding SDRAM port initiator: FIFO-buffered commands, one-cycle strobes,
// timeout with a quiet guard period, one response per command, stray-strobe counter.
module sdram_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int GUARD      = 16
) (
  input  logic              clk,
  input  logic              reset,
  sdram_initiator_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GUARD + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_GUARD = 3'd4;

  logic [54:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [54:0]   head;

  logic [2:0]    state_q, state_d;
  logic          act_write_q, act_write_d;
  logic [21:0]   act_addr_q, act_addr_d;
  logic [31:0]   act_wdata_q, act_wdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          rsp_write_q, rsp_write_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [7:0]    err_q, err_d;
  logic          stray_rdy, stray_dn;
  logic [8:0]    err_sum;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;
  assign head  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    act_write_d   = act_write_q;
    act_addr_d    = act_addr_q;
    act_wdata_d   = act_wdata_q;
    timer_d       = timer_q;
    guard_d       = guard_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    stray_rdy     = bus.sdram_ready;
    stray_dn      = bus.sdram_done;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          {act_write_d, act_addr_d, act_wdata_d} = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // timer counts cycles since ISSUE, so TIMEOUT-1 is the last legal completion cycle
        timer_d = TW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (act_write_q) begin
          stray_dn = 1'b0;
        end else begin
          stray_rdy = 1'b0;
        end
        if (act_write_q && bus.sdram_done) begin
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (!act_write_q && bus.sdram_ready) begin
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = bus.sdram_data_out;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_write_d   = act_write_q;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          guard_d = '0;
          state_d = rsp_timeout_q ? S_GUARD : S_IDLE;
        end
      end
      S_GUARD: begin
        if (guard_q == GW'(GUARD - 1)) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_sum = {1'b0, err_q} + 9'(stray_rdy) + 9'(stray_dn);
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      act_write_q   <= 1'b0;
      act_addr_q    <= '0;
      act_wdata_q   <= '0;
      timer_q       <= '0;
      guard_q       <= '0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      act_write_q   <= act_write_d;
      act_addr_q    <= act_addr_d;
      act_wdata_q   <= act_wdata_d;
      timer_q       <= timer_d;
      guard_q       <= guard_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_q         <= err_d;
    end
  end

  assign bus.cmd_ready     = !full;
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_write     = rsp_write_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_timeout   = rsp_timeout_q;
  assign bus.sdram_addr    = act_addr_q;
  assign bus.sdram_data_in = act_wdata_q;
  assign bus.sdram_req     = (state_q == S_ISSUE) && !act_write_q;
  assign bus.sdram_write   = (state_q == S_ISSUE) && act_write_q;
  assign bus.busy          = (state_q != S_IDLE) || !empty;
  assign bus.err_count     = err_q;

endmodule

// File: tb/tb_sdram_initiator.sv
// Bench for sdram_initiator: vector table, hand-built corner sequences and a random
// run, all against a latency-programmable controller model and a memory reference.
module tb_sdram_initiator;

  logic clk;
  logic reset;
  sdram_initiator_if bus();

  sdram_initiator #(.FIFO_DEPTH(4), .TIMEOUT(64), .GUARD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // device memory (controller side) and reference memory (expected side)
  logic [31:0] dev_mem [logic [21:0]];
  logic [31:0] ref_mem [logic [21:0]];

  function automatic logic [31:0] dflt(input logic [21:0] a);
    return {10'h0, a} ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] dev_rd(input logic [21:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [21:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // controller model: latency per command taken from lat_q (0 = never answers)
  int          lat_q[$];
  int          issue_cyc_q[$];
  int          pend = 0;
  int          nstrobe = 0;
  logic        hold_en;
  logic        last_wr;
  logic [21:0] last_addr;
  logic [31:0] last_data;
  logic        ctl_ready, ctl_done, inj_ready, inj_done;
  logic [31:0] ctl_data;

  assign bus.sdram_ready    = ctl_ready | inj_ready;
  assign bus.sdram_done     = ctl_done | inj_done;
  assign bus.sdram_data_out = ctl_data;

  always @(posedge clk) begin
    #1;
    ctl_ready = 1'b0;
    ctl_done  = 1'b0;
    if (pend > 0) begin
      if (hold_en) begin
        chk("addr_held", bus.sdram_addr, last_addr);
        chk("wdata_held", bus.sdram_data_in, last_data);
        chk("strobe_single_cycle", {bus.sdram_req, bus.sdram_write}, 2'b00);
      end
      pend--;
      if (pend == 0) begin
        if (last_wr) begin
          ctl_done = 1'b1;
          dev_mem[last_addr] = last_data;
        end else begin
          ctl_ready = 1'b1;
          ctl_data  = dev_rd(bus.sdram_addr);
        end
      end
    end else if (bus.sdram_req || bus.sdram_write) begin
      chk("one_strobe", bus.sdram_req & bus.sdram_write, 1'b0);
      last_wr   = bus.sdram_write;
      last_addr = bus.sdram_addr;
      last_data = bus.sdram_data_in;
      nstrobe++;
      issue_cyc_q.push_back(cyc);
      pend = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    end
  end

  task automatic push(input logic w, input logic [21:0] a, input logic [31:0] d, input int lat);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) chk("cmd_accept_wait", 0, 1);
    else lat_q.push_back(lat);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic w, output logic [31:0] d, output logic to,
                         output int ic, output int rc, output int hc, input int stall);
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    w = bus.rsp_write; d = bus.rsp_rdata; to = bus.rsp_timeout;
    rc = cyc;
    if (!bus.rsp_valid) chk("rsp_arrival_wait", 0, 1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("rsp_stable", {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata},
          {1'b1, w, to, d});
    end
    hc = cyc;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    ic = (issue_cyc_q.size() > 0) ? issue_cyc_q.pop_front() : -1000;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout, bus.rsp_rdata}, 0);
    chk({tag, "_strobes"}, {bus.sdram_req, bus.sdram_write}, 0);
    chk({tag, "_port"}, {bus.sdram_addr, bus.sdram_data_in}, 0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_err"}, bus.err_count, 0);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (issue_cyc_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (issue_cyc_q.size() == 0) chk("issue_wait", 0, 1);
  endtask

  typedef struct {
    logic        w;
    logic [21:0] a;
    logic [31:0] d;
    int          lat;
    logic        ew;
    logic [31:0] er;
    logic        et;
  } vec_t;

  typedef struct {
    logic        w;
    logic [31:0] r;
    logic        to;
    int          lat;
  } exp_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    exp_t        exq[$];
    exp_t        e;
    logic        w, to;
    logic [31:0] r;
    int          ic, rc, hc, ic2, hs, base, seen, exp_err;

    tbl[0] = '{1'b0, 22'h000100, 32'h0,         7,  1'b0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b1, 22'h3FFFFF, 32'h12345678, 7,  1'b1, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 22'h3FFFFF, 32'h0,         7,  1'b0, 32'h12345678, 1'b0};
    tbl[3] = '{1'b0, 22'h000010, 32'h0,         0,  1'b0, 32'h0,        1'b1};
    tbl[4] = '{1'b0, 22'h000100, 32'h0,         1,  1'b0, 32'hDEADBEEF, 1'b0};
    tbl[5] = '{1'b1, 22'h000000, 32'hCAFEF00D, 63, 1'b1, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 22'h000000, 32'h0,         3,  1'b0, 32'hCAFEF00D, 1'b0};
    tbl[7] = '{1'b1, 22'h2AAAAA, 32'h11112222, 0,  1'b1, 32'h0,        1'b1};
    tbl[8] = '{1'b0, 22'h2AAAAA, 32'h0,         5,  1'b0, 32'h5A70AAAA, 1'b0};

    dev_mem[22'h000100] = 32'hDEADBEEF;
    ref_mem[22'h000100] = 32'hDEADBEEF;
    exp_err = 0;
    hold_en = 1'b1;
    ctl_ready = 0; ctl_done = 0; inj_ready = 0; inj_done = 0; ctl_data = '0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // vector table
    base = nstrobe;
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat);
      get_rsp(w, r, to, ic, rc, hc, 0);
      chk($sformatf("row%0d_write", i), w, tbl[i].ew);
      chk($sformatf("row%0d_rdata", i), r, tbl[i].er);
      chk($sformatf("row%0d_timeout", i), to, tbl[i].et);
      chk($sformatf("row%0d_latency", i), rc - ic, (tbl[i].lat == 0) ? 64 : tbl[i].lat + 1);
      chk($sformatf("row%0d_addr", i), last_addr, tbl[i].a);
      if (tbl[i].w) chk($sformatf("row%0d_wdata", i), last_data, tbl[i].d);
      chk($sformatf("row%0d_strobes", i), nstrobe - base, i + 1);
      if (tbl[i].w && !tbl[i].et) ref_mem[tbl[i].a] = tbl[i].d;
    end
    repeat (20) @(negedge clk);
    chk("table_err", bus.err_count, exp_err);

    // back-to-back throughput with rsp_ready tied high
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 22'h000100, 32'h0, 7);
    begin
      int n = 0;
      while (issue_cyc_q.size() < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("tput_issues", issue_cyc_q.size(), 3);
    ic = issue_cyc_q.pop_front();
    ic2 = issue_cyc_q.pop_front();
    chk("tput_gap1", ic2 - ic, 10);
    ic = issue_cyc_q.pop_front();
    chk("tput_gap2", ic - ic2, 10);
    repeat (12) @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("tput_idle", bus.busy, 1'b0);

    // FIFO full with response stalled
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("full_ready_before_%0d", i), bus.cmd_ready, 1'b1);
      push(1'b0, 22'h000200 + 22'(i), 32'h0, 7);
    end
    chk("full_ready_low", bus.cmd_ready, 1'b0);
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("full_in_resp", {bus.rsp_valid, bus.cmd_ready, bus.busy}, 3'b101);
    base = nstrobe;
    for (int i = 0; i < 5; i++) begin
      get_rsp(w, r, to, ic, rc, hc, (i == 0) ? 6 : 0);
      if (i == 0) chk("full_no_issue_in_resp", nstrobe - base, 0);
      chk($sformatf("full_rsp%0d", i), {w, to, r}, {2'b00, ref_rd(22'h000200 + 22'(i))});
    end

    // timeout followed by guard, queued read behind it
    push(1'b0, 22'h000010, 32'h0, 0);
    push(1'b0, 22'h000104, 32'h0, 7);
    get_rsp(w, r, to, ic, rc, hc, 0);
    chk("to_fields", {w, to, r}, {2'b01, 32'h0});
    chk("to_latency", rc - ic, 64);
    hs = hc;
    get_rsp(w, r, to, ic2, rc, hc, 0);
    chk("guard_issue_gap", ic2 - hs, 18);
    chk("guard_next_rdata", r, ref_rd(22'h000104));

    // stray done during read WAIT, late ready during GUARD
    chk("stray_err0", bus.err_count, exp_err);
    push(1'b0, 22'h000100, 32'h0, 7);
    wait_issue();
    repeat (2) @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    exp_err++;
    get_rsp(w, r, to, ic, rc, hc, 0);
    chk("stray_read_data", {w, to, r}, {2'b00, ref_rd(22'h000100)});
    chk("stray_err1", bus.err_count, exp_err);
    push(1'b0, 22'h000010, 32'h0, 0);
    get_rsp(w, r, to, ic, rc, hc, 0);
    chk("stray_timeout", to, 1'b1);
    repeat (2) @(negedge clk);
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    exp_err++;
    chk("stray_err2", bus.err_count, exp_err);
    chk("stray_no_rsp", bus.rsp_valid, 1'b0);
    repeat (20) @(negedge clk);

    // reset in the middle of WAIT
    push(1'b0, 22'h000105, 32'h0, 7);
    wait_issue();
    hold_en = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_mid");
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("rst_no_rsp", seen, 0);
    exp_err = 1;
    chk("rst_late_err", bus.err_count, exp_err);
    hold_en = 1'b1;
    issue_cyc_q.delete();
    lat_q.delete();

    // random traffic against the reference memory
    for (int b = 0; b < 20; b++) begin
      int nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        logic        cw  = 1'($urandom_range(0, 1));
        logic [21:0] ca  = ($urandom_range(0, 9) == 0) ? 22'h3FFFFF : 22'h000100 + 22'($urandom_range(0, 7));
        logic [31:0] cd  = $urandom;
        int          sel = $urandom_range(0, 19);
        int          cl  = (sel == 0) ? 0 : (sel == 1) ? 63 : $urandom_range(1, 12);
        e.w   = cw;
        e.to  = (cl == 0);
        e.r   = (cw || cl == 0) ? 32'h0 : ref_rd(ca);
        e.lat = (cl == 0) ? 64 : cl + 1;
        if (cw && cl != 0) ref_mem[ca] = cd;
        exq.push_back(e);
        push(cw, ca, cd, cl);
      end
      for (int k = 0; k < nb; k++) begin
        e = exq.pop_front();
        get_rsp(w, r, to, ic, rc, hc, $urandom_range(0, 3));
        chk($sformatf("rnd%0d_%0d_rsp", b, k), {w, to, r}, {e.w, e.to, e.r});
        chk($sformatf("rnd%0d_%0d_lat", b, k), rc - ic, e.lat);
      end
    end
    repeat (20) @(negedge clk);
    chk("rnd_err", bus.err_count, exp_err);
    chk("rnd_idle", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
